// File: rtl/shift_pkg.sv
// Shared definitions for the shift datapath: default widths and the
// normalizer state encoding.
package shift_pkg;

    localparam int NORM_W       = 8;
    localparam int NORM_SAW     = 3;
    localparam int NORM_AMT_MAX = NORM_W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_e;

endpackage

// File: rtl/barrel_shifter.sv
// Logarithmic barrel shifter; direction=1 shifts right, 0 shifts left, zero fill.
// Used after the normalizer to restore the original operand.
module barrel_shifter #(
    parameter int W   = 8,
    parameter int SAW = 3
) (
    input  logic [W-1:0]   in_data,
    input  logic [SAW-1:0] amt,
    input  logic           direction,
    output logic [W-1:0]   out_data
);

    logic [W-1:0] stage [SAW+1];

    assign stage[0] = in_data;

    // Stage gi shifts by 2**gi when amt bit gi is set.
    generate
        for (genvar gi = 0; gi < SAW; gi++) begin : g_stage
            assign stage[gi+1] = !amt[gi]  ? stage[gi] :
                                 direction ? (stage[gi] >> (1 << gi)) :
                                             (stage[gi] << (1 << gi));
        end
    endgenerate

    assign out_data = stage[SAW];

endmodule

// File: rtl/shift_normalizer.sv
// Sequential normalizer: shifts the operand left one bit per cycle until the
// MSB is set, reporting the normalized value and the leading-zero count.
module shift_normalizer
    import shift_pkg::*;
#(
    parameter int W   = NORM_W,
    parameter int SAW = NORM_SAW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [SAW-1:0] out_amt,
    output logic           out_zero
);

    norm_state_e    state_q, state_next;
    logic [W-1:0]   data_q, data_next;
    logic [SAW-1:0] cnt_q, cnt_next;
    logic           zero_q, zero_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            data_q  <= data_next;
            cnt_q   <= cnt_next;
            zero_q  <= zero_next;
        end
    end

    always_comb begin
        state_next = state_q;
        data_next  = data_q;
        cnt_next   = cnt_q;
        zero_next  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_next = in_data;
                    cnt_next  = '0;
                    zero_next = (in_data == '0);
                    if (in_data == '0 || in_data[W-1]) begin
                        state_next = DONE;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_next = data_q << 1;
                cnt_next  = cnt_q + SAW'(1);
                // The bit below the MSB moves into the MSB on this shift.
                if (data_q[W-2]) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs come from registered state only; rst blanks them while asserted.
    assign in_ready  = !rst && (state_q == IDLE);
    assign out_valid = !rst && (state_q == DONE);
    assign out_data  = rst ? '0 : data_q;
    assign out_amt   = rst ? '0 : cnt_q;
    assign out_zero  = !rst && zero_q;

endmodule
